// File: rtl/soul_controller_if.sv
// rtl/soul_controller_if.sv - UART receive/transmit handshake bundle for the soul controller
interface soul_controller_if;
  logic [7:0] rx_data;
  logic       rx_receive;
  logic       tx_idle;
  logic [7:0] tx_data;
  logic       tx_transmit;

  modport master (
    output rx_data,
    output rx_receive,
    output tx_idle,
    input  tx_data,
    input  tx_transmit
  );

  modport slave (
    input  rx_data,
    input  rx_receive,
    input  tx_idle,
    output tx_data,
    output tx_transmit
  );
endinterface

// File: rtl/soul_controller.sv
// rtl/soul_controller.sv - keyboard-driven soul position/colour with per-frame clamped moves and UART echo
module soul_controller #(
  parameter int WIDTH  = 640,
  parameter int HEIGHT = 480,
  parameter int R      = 5,
  parameter int STEP   = 4,
  parameter int X_INIT = 320,
  parameter int Y_INIT = 240
) (
  input  logic                clk,
  input  logic                rst,
  soul_controller_if.slave    uart,
  input  logic                animate,
  output logic [15:0]         o_cx,
  output logic [15:0]         o_cy,
  output logic [11:0]         o_color,
  output logic [7:0]          o_drop_count
);

  typedef enum logic [1:0] {MV_NONE, MV_NEG, MV_POS} move_t;
  typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_BUSY} tx_state_t;

  localparam logic [16:0] R17    = 17'(R);
  localparam logic [16:0] STEP17 = 17'(STEP);
  localparam logic [16:0] X_HI   = 17'(WIDTH - 1 - R);
  localparam logic [16:0] Y_HI   = 17'(HEIGHT - 1 - R);

  logic        cmd_valid;
  logic [7:0]  echo_byte;
  logic        set_color;
  logic [11:0] color_val;
  move_t       mv_x, mv_y;
  move_t       pend_x, pend_y;

  always_comb begin
    cmd_valid = 1'b0;
    echo_byte = 8'h00;
    set_color = 1'b0;
    color_val = 12'h000;
    mv_x      = MV_NONE;
    mv_y      = MV_NONE;
    if (uart.rx_receive) begin
      case (uart.rx_data)
        8'h77: begin cmd_valid = 1'b1; echo_byte = 8'h57; mv_y = MV_NEG; end
        8'h73: begin cmd_valid = 1'b1; echo_byte = 8'h53; mv_y = MV_POS; end
        8'h61: begin cmd_valid = 1'b1; echo_byte = 8'h41; mv_x = MV_NEG; end
        8'h64: begin cmd_valid = 1'b1; echo_byte = 8'h44; mv_x = MV_POS; end
        8'h63: begin cmd_valid = 1'b1; echo_byte = 8'h43; set_color = 1'b1; color_val = 12'h0FF; end
        8'h6D: begin cmd_valid = 1'b1; echo_byte = 8'h4D; set_color = 1'b1; color_val = 12'hF0F; end
        8'h79: begin cmd_valid = 1'b1; echo_byte = 8'h59; set_color = 1'b1; color_val = 12'hFF0; end
        8'h20: begin cmd_valid = 1'b1; echo_byte = 8'h5A; set_color = 1'b1; color_val = 12'hFFF; end
        default: ;
      endcase
    end
  end

  // A command arriving with animate lands after the clear, so it waits for the next frame
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_x <= MV_NONE;
      pend_y <= MV_NONE;
    end else begin
      if (animate) begin
        pend_x <= MV_NONE;
        pend_y <= MV_NONE;
      end
      if (mv_x != MV_NONE) pend_x <= mv_x;
      if (mv_y != MV_NONE) pend_y <= mv_y;
    end
  end

  function automatic logic [15:0] step_axis(input logic [15:0] c, input move_t m,
                                            input logic [16:0] hi);
    logic [16:0] c17;
    logic [16:0] r;
    c17 = {1'b0, c};
    r   = c17;
    case (m)
      MV_NEG:  r = (c17 < R17 + STEP17) ? R17 : c17 - STEP17;
      MV_POS:  r = (c17 + STEP17 > hi) ? hi : c17 + STEP17;
      default: r = c17;
    endcase
    return r[15:0];
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      o_cx    <= 16'(X_INIT);
      o_cy    <= 16'(Y_INIT);
      o_color <= 12'hFFF;
    end else begin
      if (animate) begin
        o_cx <= step_axis(o_cx, pend_x, X_HI);
        o_cy <= step_axis(o_cy, pend_y, Y_HI);
      end
      if (set_color) o_color <= color_val;
    end
  end

  logic [7:0] fifo_mem [4];
  logic [1:0] wr_ptr, rd_ptr;
  logic [2:0] count;
  logic       fifo_full, fifo_empty;
  logic       pop, push_ok, drop;

  assign fifo_full  = (count == 3'd4);
  assign fifo_empty = (count == 3'd0);
  // When full, a same-cycle pop frees the slot the push writes into
  assign push_ok    = cmd_valid && (!fifo_full || pop);
  assign drop       = cmd_valid && fifo_full && !pop;

  always_ff @(posedge clk) begin
    if (push_ok) fifo_mem[wr_ptr] <= echo_byte;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr       <= 2'd0;
      rd_ptr       <= 2'd0;
      count        <= 3'd0;
      o_drop_count <= 8'd0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 2'd1;
      if (pop)     rd_ptr <= rd_ptr + 2'd1;
      if (push_ok && !pop)      count <= count + 3'd1;
      else if (!push_ok && pop) count <= count - 3'd1;
      if (drop && o_drop_count != 8'hFF) o_drop_count <= o_drop_count + 8'd1;
    end
  end

  tx_state_t state, state_next;

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    pop        = 1'b0;
    case (state)
      ST_IDLE: if (!fifo_empty && uart.tx_idle) begin
        pop        = 1'b1;
        state_next = ST_SEND;
      end
      ST_SEND: if (!uart.tx_idle) state_next = ST_BUSY;
      ST_BUSY: if (uart.tx_idle)  state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  logic [7:0] tx_data_q;

  always_ff @(posedge clk) begin
    if (rst)      tx_data_q <= 8'h00;
    else if (pop) tx_data_q <= fifo_mem[rd_ptr];
  end

  assign uart.tx_data     = tx_data_q;
  assign uart.tx_transmit = (state == ST_SEND);

endmodule

// File: tb/tb_soul_controller.sv
// tb/tb_soul_controller.sv - randomized self-checking bench for soul_controller
module tb_soul_controller;
  localparam int W = 640, H = 480, R = 5, STEP = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        animate = 1'b0;
  logic [15:0] o_cx, o_cy;
  logic [11:0] o_color;
  logic [7:0]  o_drop_count;

  soul_controller_if ifc ();

  soul_controller dut (
    .clk          (clk),
    .rst          (rst),
    .uart         (ifc),
    .animate      (animate),
    .o_cx         (o_cx),
    .o_cy         (o_cy),
    .o_color      (o_color),
    .o_drop_count (o_drop_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  int          mx, my, px, py, mdrop;
  logic [11:0] mcolor;
  logic [7:0]  exp_q [$];
  int          n_echo = 0;

  bit         tx_auto = 1'b0;
  int         tx_phase = 0, hold_cnt = 0, busy_cnt = 0;
  logic [7:0] held = 8'h00;

  logic [7:0] cmds [8] = '{8'h77, 8'h73, 8'h61, 8'h64, 8'h63, 8'h6D, 8'h79, 8'h20};

  function void model_reset();
    mx = 320; my = 240; px = 0; py = 0; mdrop = 0; mcolor = 12'hFFF;
    exp_q.delete();
  endfunction

  function int clamp(int v, int lim);
    if (v < R) return R;
    if (v > lim - 1 - R) return lim - 1 - R;
    return v;
  endfunction

  function void model_frame();
    mx = clamp(mx + STEP * px, W);
    my = clamp(my + STEP * py, H);
    px = 0;
    py = 0;
  endfunction

  function bit is_cmd(logic [7:0] b);
    foreach (cmds[i]) if (cmds[i] == b) return 1'b1;
    return 1'b0;
  endfunction

  function void model_byte(logic [7:0] b);
    int echo;
    echo = -1;
    case (b)
      8'h77: begin py = -1; echo = 'h57; end
      8'h73: begin py = 1;  echo = 'h53; end
      8'h61: begin px = -1; echo = 'h41; end
      8'h64: begin px = 1;  echo = 'h44; end
      8'h63: begin mcolor = 12'h0FF; echo = 'h43; end
      8'h6D: begin mcolor = 12'hF0F; echo = 'h4D; end
      8'h79: begin mcolor = 12'hFF0; echo = 'h59; end
      8'h20: begin mcolor = 12'hFFF; echo = 'h5A; end
      default: ;
    endcase
    if (echo >= 0) begin
      if (exp_q.size() < 4) exp_q.push_back(8'(echo));
      else if (mdrop < 255) mdrop++;
    end
  endfunction

  // Advances one cycle and plays the transmitter side of the handshake
  task tick();
    @(posedge clk);
    #1;
    if (tx_auto) begin
      case (tx_phase)
        0: if (ifc.tx_transmit === 1'b1) begin
          held = ifc.tx_data;
          n_echo++;
          n_checks++;
          if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL echo_unexpected got=%02h required=none", held);
          end else begin
            if (held !== exp_q[0]) begin
              n_fail++;
              $display("FAIL echo_order got=%02h required=%02h", held, exp_q[0]);
            end
            void'(exp_q.pop_front());
          end
          hold_cnt = $urandom_range(0, 2);
          if (hold_cnt == 0) begin
            ifc.tx_idle = 1'b0;
            busy_cnt = $urandom_range(1, 4);
            tx_phase = 2;
          end else tx_phase = 1;
        end
        1: begin
          n_checks++;
          if (ifc.tx_transmit !== 1'b1 || ifc.tx_data !== held) begin
            n_fail++;
            $display("FAIL echo_hold got=%b/%02h required=1/%02h", ifc.tx_transmit, ifc.tx_data, held);
          end
          hold_cnt--;
          if (hold_cnt == 0) begin
            ifc.tx_idle = 1'b0;
            busy_cnt = $urandom_range(1, 4);
            tx_phase = 2;
          end
        end
        default: begin
          n_checks++;
          if (ifc.tx_transmit !== 1'b0) begin
            n_fail++;
            $display("FAIL echo_release got=%b required=0", ifc.tx_transmit);
          end
          busy_cnt--;
          if (busy_cnt == 0) begin
            ifc.tx_idle = 1'b1;
            tx_phase = 0;
          end
        end
      endcase
    end
  endtask

  task send(input logic [7:0] b, input bit anim);
    ifc.rx_data = b;
    ifc.rx_receive = 1'b1;
    animate = anim;
    if (anim) model_frame();
    model_byte(b);
    tick();
    ifc.rx_receive = 1'b0;
    animate = 1'b0;
  endtask

  task pulse_anim();
    animate = 1'b1;
    model_frame();
    tick();
    animate = 1'b0;
  endtask

  task drain();
    int cnt;
    cnt = 0;
    while ((exp_q.size() != 0 || tx_phase != 0) && cnt < 300) begin
      tick();
      cnt++;
    end
    n_checks++;
    if (cnt >= 300) begin
      n_fail++;
      $display("FAIL drain_timeout pending=%0d required=0", exp_q.size());
    end
    repeat (4) tick();
  endtask

  task test_reset();
    ifc.rx_data = 8'h00; ifc.rx_receive = 1'b0; ifc.tx_idle = 1'b1;
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    model_reset();
    n_checks++;
    if (o_cx !== 16'd320 || o_cy !== 16'd240) begin
      n_fail++; $display("FAIL reset_pos got=%0d,%0d required=320,240", o_cx, o_cy);
    end
    n_checks++;
    if (o_color !== 12'hFFF || ifc.tx_transmit !== 1'b0) begin
      n_fail++; $display("FAIL reset_color_tx got=%03h/%b required=fff/0", o_color, ifc.tx_transmit);
    end
    n_checks++;
    if (o_drop_count !== 8'd0 || ifc.tx_data !== 8'h00) begin
      n_fail++; $display("FAIL reset_drop_data got=%0d/%02h required=0/00", o_drop_count, ifc.tx_data);
    end
    repeat (3) pulse_anim();
    n_checks++;
    if (o_cx !== 16'd320 || o_cy !== 16'd240) begin
      n_fail++; $display("FAIL idle_frames got=%0d,%0d required=320,240", o_cx, o_cy);
    end
    tx_auto = 1'b1;
  endtask

  task test_move();
    int base;
    base = n_echo;
    send(8'h77, 1'b0);
    send(8'h64, 1'b0);
    pulse_anim();
    n_checks++;
    if (o_cx !== 16'd324 || o_cy !== 16'd236) begin
      n_fail++; $display("FAIL move_dw got=%0d,%0d required=324,236", o_cx, o_cy);
    end
    send(8'h61, 1'b0);
    send(8'h64, 1'b0);
    send(8'h61, 1'b0);
    pulse_anim();
    n_checks++;
    if (o_cx !== 16'd320 || o_cy !== 16'd236) begin
      n_fail++; $display("FAIL move_ada got=%0d,%0d required=320,236", o_cx, o_cy);
    end
    drain();
    n_checks++;
    if (n_echo - base !== 5) begin
      n_fail++; $display("FAIL move_echo_count got=%0d required=5", n_echo - base);
    end
  endtask

  task test_boundary();
    for (int i = 0; i < 80; i++) begin
      send(8'h61, 1'b0);
      pulse_anim();
      n_checks++;
      if (o_cx !== 16'(mx)) begin
        n_fail++; $display("FAIL left_step got=%0d required=%0d", o_cx, mx);
      end
      drain();
    end
    n_checks++;
    if (o_cx !== 16'd5) begin
      n_fail++; $display("FAIL left_clamp got=%0d required=5", o_cx);
    end
    for (int i = 0; i < 70; i++) begin
      send(8'h73, 1'b0);
      pulse_anim();
      n_checks++;
      if (o_cy !== 16'(my)) begin
        n_fail++; $display("FAIL down_step got=%0d required=%0d", o_cy, my);
      end
      drain();
    end
    n_checks++;
    if (o_cy !== 16'd474) begin
      n_fail++; $display("FAIL down_clamp got=%0d required=474", o_cy);
    end
  endtask

  task test_color();
    int base;
    send(8'h6D, 1'b0);
    n_checks++;
    if (o_color !== 12'hF0F) begin
      n_fail++; $display("FAIL color_m got=%03h required=f0f", o_color);
    end
    drain();
    base = n_echo;
    send(8'h41, 1'b0);
    drain();
    n_checks++;
    if (o_color !== 12'hF0F || n_echo !== base) begin
      n_fail++; $display("FAIL ignore_A got=%03h/%0d required=f0f/0", o_color, n_echo - base);
    end
  endtask

  task test_overflow();
    int base;
    drain();
    tx_auto = 1'b0;
    ifc.tx_idle = 1'b0;
    repeat (2) tick();
    base = n_echo;
    send(8'h77, 1'b0); send(8'h73, 1'b0); send(8'h61, 1'b0);
    send(8'h64, 1'b0); send(8'h63, 1'b0); send(8'h79, 1'b0);
    tick();
    n_checks++;
    if (o_drop_count !== 8'(mdrop) || mdrop != 2) begin
      n_fail++; $display("FAIL drop_count got=%0d required=%0d", o_drop_count, mdrop);
    end
    n_checks++;
    if (ifc.tx_transmit !== 1'b0) begin
      n_fail++; $display("FAIL tx_while_busy got=%b required=0", ifc.tx_transmit);
    end
    tx_phase = 0;
    ifc.tx_idle = 1'b1;
    tx_auto = 1'b1;
    drain();
    n_checks++;
    if (n_echo - base !== 4) begin
      n_fail++; $display("FAIL overflow_echoes got=%0d required=4", n_echo - base);
    end
  endtask

  task test_simultaneous();
    int cx0, cy0;
    pulse_anim();
    send(8'h64, 1'b0);
    cx0 = mx; cy0 = my;
    send(8'h77, 1'b1);
    n_checks++;
    if (o_cx !== 16'(cx0 + 4) || o_cy !== 16'(cy0)) begin
      n_fail++; $display("FAIL simul_frame got=%0d,%0d required=%0d,%0d", o_cx, o_cy, cx0 + 4, cy0);
    end
    pulse_anim();
    n_checks++;
    if (o_cx !== 16'(cx0 + 4) || o_cy !== 16'(cy0 - 4)) begin
      n_fail++; $display("FAIL simul_next got=%0d,%0d required=%0d,%0d", o_cx, o_cy, cx0 + 4, cy0 - 4);
    end
    drain();
  endtask

  task test_reset_in_send();
    int waited;
    bit seen;
    tx_auto = 1'b0;
    ifc.tx_idle = 1'b1;
    send(8'h63, 1'b0); send(8'h6D, 1'b0); send(8'h79, 1'b0);
    waited = 0;
    seen = ifc.tx_transmit;
    while (!seen && waited < 10) begin
      tick();
      seen = ifc.tx_transmit;
      waited++;
    end
    n_checks++;
    if (!seen) begin
      n_fail++; $display("FAIL send_timeout got=0 required=1");
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_reset();
    n_checks++;
    if (ifc.tx_transmit !== 1'b0 || o_color !== 12'hFFF || o_cx !== 16'd320) begin
      n_fail++; $display("FAIL reset_in_send got=%b/%03h/%0d required=0/fff/320", ifc.tx_transmit, o_color, o_cx);
    end
    for (int i = 0; i < 6; i++) begin
      tick();
      n_checks++;
      if (ifc.tx_transmit !== 1'b0) begin
        n_fail++; $display("FAIL fifo_flushed got=%b required=0", ifc.tx_transmit);
      end
    end
    tx_phase = 0;
    tx_auto = 1'b1;
  endtask

  task test_random();
    int nrec, len;
    logic [7:0] b;
    for (int k = 0; k < 30; k++) begin
      nrec = 0;
      len = $urandom_range(1, 8);
      for (int j = 0; j < len; j++) begin
        if ($urandom_range(0, 2) == 0) b = 8'($urandom_range(0, 255));
        else b = cmds[$urandom_range(0, 7)];
        if (is_cmd(b)) begin
          if (nrec >= 4) b = 8'h00;
          else nrec++;
        end
        send(b, $urandom_range(0, 3) == 0);
        n_checks++;
        if (o_cx !== 16'(mx) || o_cy !== 16'(my) || o_color !== mcolor) begin
          n_fail++;
          $display("FAIL random_state got=%0d,%0d,%03h required=%0d,%0d,%03h", o_cx, o_cy, o_color, mx, my, mcolor);
        end
      end
      pulse_anim();
      n_checks++;
      if (o_cx !== 16'(mx) || o_cy !== 16'(my)) begin
        n_fail++; $display("FAIL random_frame got=%0d,%0d required=%0d,%0d", o_cx, o_cy, mx, my);
      end
      drain();
    end
    n_checks++;
    if (o_drop_count !== 8'(mdrop)) begin
      n_fail++; $display("FAIL random_drops got=%0d required=%0d", o_drop_count, mdrop);
    end
  endtask

  initial begin
    test_reset();
    test_move();
    test_boundary();
    test_color();
    test_overflow();
    test_simultaneous();
    test_reset_in_send();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout required=finish");
    $fatal(1, "watchdog expired");
  end
endmodule
